// File: rtl/ds_operand_stage_if.sv
// rtl/ds_operand_stage_if.sv - upstream/downstream handshake bundle for ds_operand_stage
// Purpose: groups the decoder-facing accept port (in_*) and the EXE-facing issue
//          port (out_*) of the operand stage.
// Ports:   slave  - the operand stage: takes in_* and out_allowin, drives in_allowin and out_*.
//          master - the surrounding pipeline (decoder + EXE), the mirror image.
interface ds_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int PW   = 64
);
    logic            in_valid;
    logic            in_allowin;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use1;
    logic            in_use2;
    logic [AW-1:0]   in_rd;
    logic            in_we;
    logic            in_ll;
    logic [PW-1:0]   in_payload;

    logic            out_valid;
    logic            out_allowin;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [AW-1:0]   out_rd;
    logic            out_we;
    logic            out_ll;
    logic [PW-1:0]   out_payload;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_we, in_ll, in_payload,
        output in_allowin,
        output out_valid, out_rs1_val, out_rs2_val, out_rd, out_we, out_ll, out_payload,
        input  out_allowin
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_we, in_ll, in_payload,
        input  in_allowin,
        input  out_valid, out_rs1_val, out_rs2_val, out_rd, out_we, out_ll, out_payload,
        output out_allowin
    );
endinterface

// File: rtl/ds_operand_stage.sv
// rtl/ds_operand_stage.sv - decode-side operand stage with forwarding, interlock and scoreboard
// Purpose: single-entry valid/allowin pipeline register holding one decoded instruction.
//          Resolves two source operands from r0, NFWD forward slots (index 0 youngest)
//          or the register file, interlocks on unready producers, on scoreboard-busy
//          sources and on a long-latency WAW, and tracks long-latency destinations.
// Ports:   clk, reset (sync, active-high), flush
//          io             - in_* accept port and out_* issue port (ds_operand_stage_if.slave)
//          rf_raddr1/2    - register-file read addresses, rf_rdata1/2 async read data
//          fwd_we/ready/addr/data - per-stage forwarding sources
//          ll_wb_valid/addr - long-latency writeback retiring a busy register
//          busy_vec       - scoreboard contents, stall_cnt - saturating stall-cycle count
module ds_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NFWD = 3,
    parameter int PW   = 64,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    ds_operand_stage_if.slave    io,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 ll_wb_valid,
    input  logic [AW-1:0]        ll_wb_addr,
    output logic [NREG-1:0]      busy_vec,
    output logic [31:0]          stall_cnt
);
    logic            valid_q,   valid_d;
    logic [AW-1:0]   rs1_q,     rs1_d;
    logic [AW-1:0]   rs2_q,     rs2_d;
    logic            use1_q,    use1_d;
    logic            use2_q,    use2_d;
    logic [AW-1:0]   rd_q,      rd_d;
    logic            we_q,      we_d;
    logic            ll_q,      ll_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic [NREG-1:0] busy_q,    busy_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic            hit1, hit2, rdy1, rdy2;
    logic [XLEN-1:0] fdata1, fdata2;
    logic            haz1, haz2, haz_waw, ready_go, fire, load;

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        hit1 = 1'b0; rdy1 = 1'b0; fdata1 = '0;
        hit2 = 1'b0; rdy2 = 1'b0; fdata2 = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs1_q) begin
                hit1   = 1'b1;
                rdy1   = fwd_ready[i];
                fdata1 = fwd_data[i*XLEN +: XLEN];
            end
            if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs2_q) begin
                hit2   = 1'b1;
                rdy2   = fwd_ready[i];
                fdata2 = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    // r0 never raises a hazard; a busy register stalls even if a forward slot matches.
    always_comb begin
        haz1     = use1_q && (rs1_q != '0) && ((hit1 && !rdy1) || busy_q[rs1_q]);
        haz2     = use2_q && (rs2_q != '0) && ((hit2 && !rdy2) || busy_q[rs2_q]);
        haz_waw  = ll_q && we_q && (rd_q != '0) && busy_q[rd_q];
        ready_go = !(haz1 || haz2 || haz_waw);
        fire     = valid_q && ready_go && !flush && io.out_allowin;
        load     = io.in_valid && io.in_allowin && !flush;
    end

    always_comb begin
        io.out_valid   = valid_q && ready_go && !flush;
        io.in_allowin  = !valid_q || (ready_go && io.out_allowin);
        io.out_rs1_val = (rs1_q == '0) ? '0 : (hit1 ? fdata1 : rf_rdata1);
        io.out_rs2_val = (rs2_q == '0) ? '0 : (hit2 ? fdata2 : rf_rdata2);
        io.out_rd      = rd_q;
        io.out_we      = we_q;
        io.out_ll      = ll_q;
        io.out_payload = payload_q;
        rf_raddr1      = rs1_q;
        rf_raddr2      = rs2_q;
        busy_vec       = busy_q;
        stall_cnt      = stall_cnt_q;
    end

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use1_d      = use1_q;
        use2_d      = use2_q;
        rd_d        = rd_q;
        we_d        = we_q;
        ll_d        = ll_q;
        payload_d   = payload_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;

        if (flush)              valid_d = 1'b0;
        else if (io.in_allowin) valid_d = io.in_valid;

        if (load) begin
            rs1_d     = io.in_rs1;
            rs2_d     = io.in_rs2;
            use1_d    = io.in_use1;
            use2_d    = io.in_use2;
            rd_d      = io.in_rd;
            we_d      = io.in_we;
            ll_d      = io.in_ll;
            payload_d = io.in_payload;
        end

        // Clear first so a same-register set in the same cycle wins.
        if (ll_wb_valid) busy_d[ll_wb_addr] = 1'b0;
        if (fire && ll_q && we_q && rd_q != '0) busy_d[rd_q] = 1'b1;
        busy_d[0] = 1'b0;

        if (valid_q && !ready_go && !flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use1_q      <= 1'b0;
            use2_q      <= 1'b0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            ll_q        <= 1'b0;
            payload_q   <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use1_q      <= use1_d;
            use2_q      <= use2_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            ll_q        <= ll_d;
            payload_q   <= payload_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_ds_operand_stage.sv
// tb/tb_ds_operand_stage.sv - directed self-checking bench for ds_operand_stage
module tb_ds_operand_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_we, fwd_ready;
    logic [14:0] fwd_addr;
    logic [95:0] fwd_data;
    logic        ll_wb_valid;
    logic [4:0]  ll_wb_addr;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ds_operand_stage_if #(.XLEN(32), .AW(5), .PW(64)) io ();

    ds_operand_stage #(.XLEN(32), .NREG(32), .NFWD(3), .PW(64)) dut (
        .clk(clk), .reset(reset), .flush(flush), .io(io),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ll_wb_valid(ll_wb_valid), .ll_wb_addr(ll_wb_addr),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush          = 1'b0;
        rf_rdata1      = '0;
        rf_rdata2      = '0;
        fwd_we         = '0;
        fwd_ready      = '0;
        fwd_addr       = '0;
        fwd_data       = '0;
        ll_wb_valid    = 1'b0;
        ll_wb_addr     = '0;
        io.out_allowin = 1'b1;
        io.in_valid    = 1'b0;
        #1;
    endtask

    task automatic drive_fields(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic we,
                                input logic ll, input logic [63:0] pl);
        io.in_rs1 = rs1; io.in_use1 = u1; io.in_rs2 = rs2; io.in_use2 = u2;
        io.in_rd = rd; io.in_we = we; io.in_ll = ll; io.in_payload = pl;
    endtask

    // Accepts one instruction (stage must be empty); it is held on return.
    task automatic load(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic ll, input logic [63:0] pl);
        drive_fields(rs1, u1, rs2, u2, rd, we, ll, pl);
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        drive_fields(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0);
        tick(); tick();
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
        checks++; if (io.in_allowin !== 1'b1) begin errors++; $display("FAIL reset_in_allowin: got %b want 1", io.in_allowin); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
        checks++; if (io.out_payload !== 64'h0 || io.out_rd !== 5'd0) begin errors++; $display("FAIL reset_fields: got %h/%h want 0/0", io.out_payload, io.out_rd); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forward_priority();
        load(5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 64'h1111);
        fwd_we = 3'b111; fwd_ready = 3'b111;
        fwd_addr = {5'd5, 5'd5, 5'd5};
        fwd_data = {32'd30, 32'd20, 32'd10};
        #1;
        checks++; if (io.out_rs1_val !== 32'd10) begin errors++; $display("FAIL fwd_youngest: got %0d want 10", io.out_rs1_val); end
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b want 1", io.out_valid); end
        checks++; if (rf_raddr1 !== 5'd5 || io.out_payload !== 64'h1111) begin errors++; $display("FAIL fwd_fields: got %0d/%h want 5/1111", rf_raddr1, io.out_payload); end
        fwd_we = 3'b110; #1;
        checks++; if (io.out_rs1_val !== 32'd20) begin errors++; $display("FAIL fwd_second: got %0d want 20", io.out_rs1_val); end
        fwd_we = 3'b100; fwd_ready = 3'b011; #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_unready_wb: got %b want 0", io.out_valid); end
        fwd_we = 3'b000; rf_rdata1 = 32'h77; #1;
        checks++; if (io.out_rs1_val !== 32'h77 || io.out_valid !== 1'b1) begin errors++; $display("FAIL fwd_rf: got %h/%b want 77/1", io.out_rs1_val, io.out_valid); end
        tick();
        clear_inputs();
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_after_fire: got %b want 0", io.out_valid); end
    endtask

    task automatic test_load_use();
        load(5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0, 64'h2222);
        fwd_we = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_ready = 3'b000; #1;
        checks++; if (io.out_valid !== 1'b0 || io.in_allowin !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b/%b want 0/0", io.out_valid, io.in_allowin); end
        tick();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
        tick();
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_cnt2: got %0d want 2", stall_cnt); end
        fwd_ready = 3'b001; fwd_data = {64'h0, 32'hDEAD}; #1;
        checks++; if (io.out_valid !== 1'b1 || io.out_rs2_val !== 32'hDEAD) begin errors++; $display("FAIL lu_release: got %b/%h want 1/dead", io.out_valid, io.out_rs2_val); end
        tick();
        clear_inputs();
        checks++; if (stall_cnt !== 32'd2 || io.out_valid !== 1'b0) begin errors++; $display("FAIL lu_after: got %0d/%b want 2/0", stall_cnt, io.out_valid); end
    endtask

    task automatic test_r0_unused();
        load(5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 64'h3333);
        fwd_we = 3'b001; fwd_addr = 15'd0; fwd_ready = 3'b000; fwd_data = {64'h0, 32'hBEEF}; #1;
        checks++; if (io.out_valid !== 1'b1 || io.out_rs1_val !== 32'h0) begin errors++; $display("FAIL r0: got %b/%h want 1/0", io.out_valid, io.out_rs1_val); end
        tick();
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 64'h4444);
        checks++; if (io.out_valid !== 1'b1 || io.out_ll !== 1'b1) begin errors++; $display("FAIL sb_div_issue: got %b/%b want 1/1", io.out_valid, io.out_ll); end
        tick();
        checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_set: got %h want 200", busy_vec); end
        load(5'd0, 1'b0, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0, 64'h5555);
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL sb_unused_busy: got %b want 1", io.out_valid); end
        tick();
        load(5'd9, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 64'h6666);
        rf_rdata1 = 32'h55; fwd_we = 3'b100; fwd_addr = {5'd9, 5'd0, 5'd0};
        fwd_ready = 3'b111; fwd_data = {32'h99, 64'h0}; #1;
        checks++; if (io.out_valid !== 1'b0 || io.in_allowin !== 1'b0) begin errors++; $display("FAIL sb_dep_stall: got %b/%b want 0/0", io.out_valid, io.in_allowin); end
        tick();
        ll_wb_valid = 1'b1; ll_wb_addr = 5'd9; #1;
        checks++; if (io.out_valid !== 1'b0 || busy_vec !== 32'h200) begin errors++; $display("FAIL sb_clear_cycle: got %b/%h want 0/200", io.out_valid, busy_vec); end
        tick();
        ll_wb_valid = 1'b0; #1;
        checks++; if (busy_vec !== 32'h0 || io.out_valid !== 1'b1) begin errors++; $display("FAIL sb_after_clear: got %h/%b want 0/1", busy_vec, io.out_valid); end
        checks++; if (io.out_rs1_val !== 32'h99 || stall_cnt !== 32'd4) begin errors++; $display("FAIL sb_value_cnt: got %h/%0d want 99/4", io.out_rs1_val, stall_cnt); end
        tick();
        clear_inputs();
        // Set and clear of r9 in the same cycle
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 64'h7777);
        ll_wb_valid = 1'b1; ll_wb_addr = 5'd9; #1;
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL sb_setclr_issue: got %b want 1", io.out_valid); end
        tick();
        ll_wb_valid = 1'b0; #1;
        checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_set_wins: got %h want 200", busy_vec); end
        // WAW: another long-latency write of busy r9
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 64'h8888);
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL sb_waw_stall: got %b want 0", io.out_valid); end
        ll_wb_valid = 1'b1; ll_wb_addr = 5'd9;
        tick();
        ll_wb_valid = 1'b0; #1;
        checks++; if (io.out_valid !== 1'b1 || busy_vec !== 32'h0 || stall_cnt !== 32'd5) begin errors++; $display("FAIL sb_waw_release: got %b/%h/%0d want 1/0/5", io.out_valid, busy_vec, stall_cnt); end
        tick();
        checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_waw_set: got %h want 200", busy_vec); end
        ll_wb_valid = 1'b1; ll_wb_addr = 5'd9;
        tick();
        clear_inputs();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_final_clear: got %h want 0", busy_vec); end
    endtask

    task automatic test_flush();
        load(5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0, 64'hAAAA);
        fwd_we = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_ready = 3'b000;
        flush = 1'b1; #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_stall_valid: got %b want 0", io.out_valid); end
        tick();
        flush = 1'b0; fwd_we = 3'b000; #1;
        checks++; if (io.out_valid !== 1'b0 || io.in_allowin !== 1'b1 || stall_cnt !== 32'd5) begin errors++; $display("FAIL fl_stall_after: got %b/%b/%0d want 0/1/5", io.out_valid, io.in_allowin, stall_cnt); end
        drive_fields(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 64'hBBBB);
        io.in_valid = 1'b1; flush = 1'b1;
        tick();
        io.in_valid = 1'b0; flush = 1'b0; #1;
        checks++; if (io.out_valid !== 1'b0 || io.out_payload !== 64'hAAAA) begin errors++; $display("FAIL fl_accept: got %b/%h want 0/aaaa", io.out_valid, io.out_payload); end
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 64'hCCCC);
        flush = 1'b1; #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_div_valid: got %b want 0", io.out_valid); end
        tick();
        clear_inputs();
        checks++; if (busy_vec !== 32'h0 || io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_div_noset: got %h/%b want 0/0", busy_vec, io.out_valid); end
    endtask

    task automatic test_backpressure();
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 64'hDDDD);
        io.out_allowin = 1'b0; #1;
        checks++; if (io.out_valid !== 1'b1 || io.in_allowin !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b/%b want 1/0", io.out_valid, io.in_allowin); end
        drive_fields(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 64'hEEEE);
        io.in_valid = 1'b1;
        tick();
        checks++; if (io.out_payload !== 64'hDDDD || io.out_rd !== 5'd5 || io.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h/%0d/%b want dddd/5/1", io.out_payload, io.out_rd, io.out_valid); end
        io.out_allowin = 1'b1; #1;
        checks++; if (io.in_allowin !== 1'b1) begin errors++; $display("FAIL bp_release_allowin: got %b want 1", io.in_allowin); end
        tick();
        checks++; if (io.out_payload !== 64'hEEEE || io.out_rd !== 5'd6 || io.out_valid !== 1'b1) begin errors++; $display("FAIL bp_next: got %h/%0d/%b want eeee/6/1", io.out_payload, io.out_rd, io.out_valid); end
        io.in_valid = 1'b0;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        load(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 64'h1);
        tick();
        checks++; if (busy_vec !== 32'h1000) begin errors++; $display("FAIL rs_set: got %h want 1000", busy_vec); end
        load(5'd12, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 64'h2);
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rs_stall: got %b want 0", io.out_valid); end
        tick();
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL rs_cnt: got %0d want 6", stall_cnt); end
        reset = 1'b1;
        tick();
        checks++; if (io.out_valid !== 1'b0 || io.in_allowin !== 1'b1) begin errors++; $display("FAIL rs_valid: got %b/%b want 0/1", io.out_valid, io.in_allowin); end
        checks++; if (busy_vec !== 32'h0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL rs_state: got %h/%0d want 0/0", busy_vec, stall_cnt); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_load_use();
        test_r0_unused();
        test_scoreboard();
        test_flush();
        test_backpressure();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
